// File: rtl/hawk_tol_list_mngr.sv
// Table-of-Lists manager: NUM_LISTS doubly-linked lists over ENTRY_CNT entries.
// Executes one POP or MOVE at a time (CHECK -> UNLINK -> LINK -> RESP).
module hawk_tol_list_mngr #(
  parameter int NUM_LISTS = 4,
  parameter int ENTRY_CNT = 16,
  parameter int ID_W      = $clog2(ENTRY_CNT + 1),
  parameter int LID_W     = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1,
  parameter int CNT_W     = $clog2(ENTRY_CNT + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       init_i,
  output logic                       init_done_o,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_op_i,
  input  logic [ID_W-1:0]            req_id_i,
  input  logic [LID_W-1:0]           req_src_i,
  input  logic [LID_W-1:0]           req_dst_i,
  output logic                       resp_valid_o,
  output logic [ID_W-1:0]            resp_id_o,
  output logic                       resp_err_o,
  output logic [NUM_LISTS*ID_W-1:0]  head_o,
  output logic [NUM_LISTS*ID_W-1:0]  tail_o,
  output logic [NUM_LISTS*CNT_W-1:0] count_o,
  output logic [NUM_LISTS-1:0]       empty_o
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CHECK, S_UNLINK, S_LINK, S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]  idx_q;
  logic             init_done_q;
  logic             op_q;
  logic [ID_W-1:0]  id_q;
  logic [LID_W-1:0] src_q;
  logic [LID_W-1:0] dst_q;
  logic             err_q;

  logic [ID_W-1:0]  next_q  [ENTRY_CNT+1];
  logic [ID_W-1:0]  prev_q  [ENTRY_CNT+1];
  logic [LID_W-1:0] owner_q [ENTRY_CNT+1];
  logic [ID_W-1:0]  head_q  [NUM_LISTS];
  logic [ID_W-1:0]  tail_q  [NUM_LISTS];
  logic [CNT_W-1:0] count_q [NUM_LISTS];

  logic            accept;
  logic            src_ok, dst_ok, id_ok, chk_err;
  logic [ID_W-1:0] pop_id;
  logic [ID_W-1:0] unl_prev, unl_next, lnk_tail;
  logic            last_idx;

  assign req_ready_o = (state_q == S_IDLE) && init_done_q && !init_i;
  assign accept      = req_valid_i && req_ready_o;
  assign init_done_o = init_done_q;
  assign last_idx    = (idx_q == ID_W'(ENTRY_CNT));

  // Indices are qualified before use so out-of-range values never select an entry.
  assign src_ok  = int'(src_q) < NUM_LISTS;
  assign dst_ok  = int'(dst_q) < NUM_LISTS;
  assign id_ok   = (id_q != '0) && (int'(id_q) <= ENTRY_CNT);
  assign pop_id  = src_ok ? head_q[src_q] : '0;
  assign chk_err = !src_ok || !dst_ok ||
                   (op_q ? (count_q[src_q] == '0)
                         : (!id_ok || owner_q[id_q] != src_q));

  assign unl_prev = prev_q[id_q];
  assign unl_next = next_q[id_q];
  assign lnk_tail = tail_q[dst_q];

  assign resp_valid_o = (state_q == S_RESP);
  assign resp_err_o   = (state_q == S_RESP) && err_q;
  assign resp_id_o    = (state_q == S_RESP && !err_q) ? id_q : '0;

  always_comb begin
    head_o  = '0;
    tail_o  = '0;
    count_o = '0;
    empty_o = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      head_o[i*ID_W +: ID_W]    = head_q[i];
      tail_o[i*ID_W +: ID_W]    = tail_q[i];
      count_o[i*CNT_W +: CNT_W] = count_q[i];
      empty_o[i]                = (count_q[i] == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   if (last_idx) state_d = S_IDLE;
      S_IDLE: begin
        if (init_i)      state_d = S_INIT;
        else if (accept) state_d = S_CHECK;
      end
      S_CHECK:  state_d = chk_err ? S_RESP : S_UNLINK;
      S_UNLINK: state_d = S_LINK;
      S_LINK:   state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= ID_W'(1);
      init_done_q <= 1'b0;
      op_q        <= 1'b0;
      id_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      err_q       <= 1'b0;
      for (int e = 0; e <= ENTRY_CNT; e++) begin
        next_q[e]  <= '0;
        prev_q[e]  <= '0;
        owner_q[e] <= '0;
      end
      for (int l = 0; l < NUM_LISTS; l++) begin
        head_q[l]  <= '0;
        tail_q[l]  <= '0;
        count_q[l] <= '0;
      end
    end else begin
      case (state_q)
        S_INIT: begin
          next_q[idx_q]  <= last_idx ? '0 : idx_q + ID_W'(1);
          prev_q[idx_q]  <= idx_q - ID_W'(1);
          owner_q[idx_q] <= '0;
          idx_q          <= idx_q + ID_W'(1);
          if (last_idx) begin
            init_done_q <= 1'b1;
            for (int l = 0; l < NUM_LISTS; l++) begin
              head_q[l]  <= (l == 0) ? ID_W'(1) : '0;
              tail_q[l]  <= (l == 0) ? ID_W'(ENTRY_CNT) : '0;
              count_q[l] <= (l == 0) ? CNT_W'(ENTRY_CNT) : '0;
            end
          end
        end
        S_IDLE: begin
          if (init_i) begin
            init_done_q <= 1'b0;
            idx_q       <= ID_W'(1);
          end else if (accept) begin
            op_q  <= req_op_i;
            id_q  <= req_id_i;
            src_q <= req_src_i;
            dst_q <= req_dst_i;
            err_q <= 1'b0;
          end
        end
        S_CHECK: begin
          if (op_q) id_q <= pop_id;
          err_q <= chk_err;
        end
        S_UNLINK: begin
          if (unl_prev != '0) next_q[unl_prev] <= unl_next;
          else                head_q[src_q]    <= unl_next;
          if (unl_next != '0) prev_q[unl_next] <= unl_prev;
          else                tail_q[src_q]    <= unl_prev;
          count_q[src_q] <= count_q[src_q] - CNT_W'(1);
        end
        S_LINK: begin
          // lnk_tail already reflects the UNLINK of the previous cycle (matters for src==dst).
          prev_q[id_q] <= lnk_tail;
          next_q[id_q] <= '0;
          if (lnk_tail != '0) next_q[lnk_tail] <= id_q;
          else                head_q[dst_q]    <= id_q;
          tail_q[dst_q]  <= id_q;
          owner_q[id_q]  <= dst_q;
          count_q[dst_q] <= count_q[dst_q] + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
